// File: rtl/dram_controller_param.sv
// FPM DRAM controller for a 68030 bus: row/column muxing, byte-lane CAS, CBR refresh
// with a queued request counter, and programmable RAS/CAS/precharge timing.
module dram_controller_param #(
    parameter int ADDR_BITS        = 12,
    parameter int NUM_BANKS        = 2,
    parameter int REFRESH_INTERVAL = 781,
    parameter int T_RCD            = 1,
    parameter int T_CAS            = 1,
    parameter int T_RP             = 2,
    parameter int T_REF            = 2,
    parameter int PORT_32          = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CS_n,
    input  logic                 AS_n,
    input  logic                 RW,
    input  logic                 SIZ0,
    input  logic                 SIZ1,
    input  logic [31:0]          ADDR,
    output logic [ADDR_BITS-1:0] ADDR_DRAM,
    output logic [NUM_BANKS-1:0] RAS_n,
    output logic [3:0]           CAS_n,
    output logic                 DRAM_WR_n,
    output logic                 DSACK0_n,
    output logic                 DSACK1_n,
    output logic                 REF_OVF,
    output logic [3:0]           dbg_state,
    output logic [2:0]           dbg_pending
);

    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ROW      = 4'd1,
        S_RAS      = 4'd2,
        S_RCD      = 4'd3,
        S_CAS      = 4'd4,
        S_CASW     = 4'd5,
        S_ACK      = 4'd6,
        S_REF_CAS  = 4'd7,
        S_REF_RAS  = 4'd8,
        S_REF_HOLD = 4'd9,
        S_REF_END  = 4'd10,
        S_PRE      = 4'd11,
        S_PRE_W    = 4'd12
    } state_t;

    state_t state, next_state;

    logic cs_m, cs_s, as_m, as_s;
    logic [TW-1:0] ref_cnt;
    logic          tick, service;
    logic [2:0]    pending;
    logic [3:0]    cnt, cnt_d;
    logic [BW-1:0] bank;
    logic [3:0]    lanes;
    logic [ADDR_BITS-1:0] row, col, addr_d;
    logic [NUM_BANKS-1:0] ras_d;
    logic [3:0]    cas_d;
    logic          wr_d, ds0_d, ds1_d;
    logic          unused_addr;

    assign row = ADDR[2 +: ADDR_BITS];
    assign col = ADDR[2 + ADDR_BITS +: ADDR_BITS];
    assign unused_addr = ^ADDR;

    generate
        if (NUM_BANKS > 1) begin : g_bank
            assign bank = ADDR[2 + 2*ADDR_BITS +: BW];
        end else begin : g_one_bank
            assign bank = '0;
        end
    endgenerate

    // Every 68030 size/offset pattern reduces to a right shift of a left-aligned mask.
    always_comb begin
        lanes = 4'b0000;
        case ({SIZ1, SIZ0})
            2'b01:   lanes = 4'b1000 >> ADDR[1:0];
            2'b10:   lanes = 4'b1100 >> ADDR[1:0];
            2'b11:   lanes = 4'b1110 >> ADDR[1:0];
            default: lanes = 4'b1111 >> ADDR[1:0];
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_m <= 1'b1;
            cs_s <= 1'b1;
            as_m <= 1'b1;
            as_s <= 1'b1;
        end else begin
            cs_m <= CS_n;
            cs_s <= cs_m;
            as_m <= AS_n;
            as_s <= as_m;
        end
    end

    assign tick    = (ref_cnt == TW'(REFRESH_INTERVAL - 1));
    assign service = (state == S_REF_CAS);

    // A tick and a serviced refresh in the same cycle cancel out.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_cnt <= '0;
            pending <= 3'd0;
            REF_OVF <= 1'b0;
        end else begin
            ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
            if (tick && pending == 3'd7)
                REF_OVF <= 1'b1;
            if (tick && !service) begin
                if (pending != 3'd7)
                    pending <= pending + 3'd1;
            end else if (!tick && service) begin
                pending <= pending - 3'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ADDR_DRAM <= '0;
            RAS_n     <= '1;
            CAS_n     <= 4'hF;
            DRAM_WR_n <= 1'b1;
            DSACK0_n  <= 1'b1;
            DSACK1_n  <= 1'b1;
        end else begin
            state     <= next_state;
            cnt       <= cnt_d;
            ADDR_DRAM <= addr_d;
            RAS_n     <= ras_d;
            CAS_n     <= cas_d;
            DRAM_WR_n <= wr_d;
            DSACK0_n  <= ds0_d;
            DSACK1_n  <= ds1_d;
        end
    end

    // Raw AS_n drives abort and end-of-cycle so a negation is seen without sync delay.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (pending != 3'd0) next_state = S_REF_CAS;
                        else if (!cs_s && !as_s) next_state = S_ROW;
            S_ROW:      next_state = S_RAS;
            S_RAS:      next_state = S_RCD;
            S_RCD:      if (AS_n) next_state = S_PRE;
                        else if (cnt == 4'd1) next_state = S_CAS;
            S_CAS:      next_state = AS_n ? S_PRE : S_CASW;
            S_CASW:     if (AS_n) next_state = S_PRE;
                        else if (cnt == 4'd1) next_state = S_ACK;
            S_ACK:      if (AS_n) next_state = S_PRE;
            S_REF_CAS:  next_state = S_REF_RAS;
            S_REF_RAS:  next_state = S_REF_HOLD;
            S_REF_HOLD: if (cnt == 4'd1) next_state = S_REF_END;
            S_REF_END:  next_state = S_PRE;
            S_PRE:      next_state = (T_RP == 1) ? S_IDLE : S_PRE_W;
            S_PRE_W:    if (cnt == 4'd1) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt;
        addr_d = ADDR_DRAM;
        ras_d  = RAS_n;
        cas_d  = CAS_n;
        wr_d   = DRAM_WR_n;
        ds0_d  = DSACK0_n;
        ds1_d  = DSACK1_n;
        case (state)
            S_ROW: begin
                addr_d = row;
                wr_d   = 1'b1;
            end
            S_RAS: begin
                ras_d = ~(NUM_BANKS'(1) << bank);
                cnt_d = 4'(T_RCD);
            end
            S_RCD: if (!AS_n) begin
                if (cnt == 4'd1) begin
                    addr_d = col;
                    wr_d   = RW;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_CAS: if (!AS_n) begin
                cas_d = ~lanes;
                cnt_d = 4'(T_CAS);
            end
            S_CASW: if (!AS_n) begin
                if (cnt == 4'd1) begin
                    ds1_d = 1'b0;
                    ds0_d = (PORT_32 != 0) ? 1'b0 : 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_REF_CAS: begin
                cas_d = 4'h0;
                wr_d  = 1'b1;
            end
            S_REF_RAS: begin
                ras_d = '0;
                cnt_d = 4'(T_REF);
            end
            S_REF_HOLD: begin
                if (cnt == 4'd1) cas_d = 4'hF;
                else cnt_d = cnt - 4'd1;
            end
            S_REF_END: ras_d = '1;
            // First precharge cycle counts toward T_RP, so the wait holds T_RP-1 more.
            S_PRE: begin
                ras_d  = '1;
                cas_d  = 4'hF;
                ds0_d  = 1'b1;
                ds1_d  = 1'b1;
                wr_d   = 1'b1;
                addr_d = '0;
                cnt_d  = 4'(T_RP - 1);
            end
            S_PRE_W: if (cnt != 4'd1) cnt_d = cnt - 4'd1;
            default: ;
        endcase
    end

    assign dbg_state   = state;
    assign dbg_pending = pending;

endmodule
